// File: rtl/i2c_target_sync.sv
// i2c_target_sync: I2C target moving one 32-bit word per transaction, with oversampled SCL/SDA synchronizers
module i2c_target_sync #(
  parameter logic [6:0] SLAVE_ADDR = 7'b0101010,
  parameter int MIN_HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        rx_done,
  output logic        busy,
  output logic [3:0]  state_out
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, RX_BYTE = 4'd3,
    RX_ACK = 4'd4, TX_BYTE = 4'd5, TX_ACK = 4'd6, WAIT_STOP = 4'd7
  } state_t;
  if (MIN_HALF < 2) begin : g_min_half
    $error("MIN_HALF must be at least 2 clk cycles");
  end
  state_t state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q;
  logic [2:0] byte_q;
  logic [7:0] sh_q;
  logic [31:0] word_q, txw_q, rx_data_q;
  logic rw_q, oe_q, busy_q, rx_done_q;
  logic scl_rise, scl_fall, start, stop, addr_hit;
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign addr_hit = sh_q[7:1] == SLAVE_ADDR;
  assign i2c_sda = oe_q ? 1'b0 : 1'bz;
  // two synchronizer stages plus a history stage for edge detection, idle-high after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], i2c_scl};
      sda_q <= {sda_q[1:0], i2c_sda};
    end
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: bus conditions win, otherwise the FSM advances on SCL falling edges
  always_comb begin
    state_d = state_q;
    if (start) state_d = ADDR;
    else if (stop) state_d = IDLE;
    else if (scl_fall) begin
      case (state_q)
        ADDR:     if (cnt_q == 4'd8) state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: state_d = rw_q ? TX_BYTE : RX_BYTE;
        RX_BYTE:  if (cnt_q == 4'd8) state_d = byte_q[2] ? WAIT_STOP : RX_ACK;
        RX_ACK:   state_d = RX_BYTE;
        TX_BYTE:  if (cnt_q == 4'd8) state_d = TX_ACK;
        TX_ACK:   state_d = sh_q[0] ? WAIT_STOP : TX_BYTE;
        default:  state_d = state_q;
      endcase
    end
  end
  // datapath: sample on SCL rise, change the SDA drive only on SCL fall
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      byte_q <= '0;
      sh_q <= '0;
      word_q <= '0;
      txw_q <= '0;
      rx_data_q <= '0;
      rw_q <= 1'b0;
      oe_q <= 1'b0;
      busy_q <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      if (start) begin
        cnt_q <= '0;
        byte_q <= '0;
        word_q <= '0;
        oe_q <= 1'b0;
      end else if (stop) begin
        cnt_q <= '0;
        oe_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        if (scl_rise) sh_q <= {sh_q[6:0], sda_q[1]};
        cnt_q <= (state_d != state_q) ? 4'd0 : scl_rise ? cnt_q + 4'd1 : cnt_q;
        if (scl_fall) begin
          case (state_q)
            ADDR: if (cnt_q == 4'd8) begin
              rw_q <= sh_q[0];
              oe_q <= addr_hit;
              busy_q <= addr_hit;
            end
            ADDR_ACK: begin
              txw_q <= tx_data;
              oe_q <= rw_q & ~tx_data[31];
            end
            RX_BYTE: if (cnt_q == 4'd8) begin
              oe_q <= ~byte_q[2];
              if (!byte_q[2]) word_q <= word_q | ({sh_q, 24'b0} >> {byte_q[1:0], 3'b0});
            end
            RX_ACK: begin
              oe_q <= 1'b0;
              byte_q <= byte_q + 3'd1;
              if (byte_q == 3'd3) begin
                rx_data_q <= word_q;
                rx_done_q <= 1'b1;
              end
            end
            TX_BYTE: begin
              txw_q <= {txw_q[30:0], 1'b1};
              oe_q <= (cnt_q != 4'd8) & ~txw_q[30];
            end
            TX_ACK: oe_q <= ~sh_q[0] & ~txw_q[31];
            default: oe_q <= 1'b0;
          endcase
        end
      end
    end
  end
  // outputs
  always_comb begin
    state_out = state_q;
    busy = busy_q;
    rx_data = rx_data_q;
    rx_done = rx_done_q;
  end
endmodule
